// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller
// Owns the 68000 bus handshake beside the address decoder. It adds a
// per-region wait-state count before DTACK, autovectors interrupt-acknowledge
// cycles through VPA, waits for expansion-bus DTACK on unselected cycles, and
// ends any cycle left unanswered for TIMEOUT clocks with BERR. All three
// strobes are registered and at most one of them is low at a time.

module bus_cycle_controller #(
   parameter int unsigned ROM_WAIT = 2,
   parameter int unsigned RAM_WAIT = 0,
   parameter int unsigned IO_WAIT  = 3,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       AS,
   input  logic       UDS,
   input  logic       LDS,
   input  logic [2:0] FC,
   input  logic       SEL_ROM,
   input  logic       SEL_RAM,
   input  logic       SEL_IO,
   input  logic       EXT_DTACK,
   input  logic       CLR_FLAG,
   output logic       DTACK,
   output logic       BERR,
   output logic       VPA,
   output logic       BERR_FLAG
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      EXTW,
      ACK,
      VACK,
      BERRS
   } state_t;

   localparam logic [15:0] ROM_W = 16'(ROM_WAIT);
   localparam logic [15:0] RAM_W = 16'(RAM_WAIT);
   localparam logic [15:0] IO_W  = 16'(IO_WAIT);
   localparam logic [8:0]  TMO   = 9'(TIMEOUT);

   state_t      state;
   logic [15:0] wcnt;
   logic [7:0]  tcnt;
   logic [8:0]  tcnt_inc;
   logic        timeout_hit;
   logic        sel_hit;
   logic [15:0] sel_w;

   // Data strobes play no part in cycle termination; an AS-only cycle is
   // still answered.
   logic unused_strobes;
   assign unused_strobes = UDS ^ LDS;

   assign tcnt_inc    = {1'b0, tcnt} + 9'd1;
   assign timeout_hit = (tcnt_inc == TMO);

   // Prioritised region decode: ROM over RAM over IO, none means expansion bus.
   always_comb begin
      sel_hit = 1'b1;
      sel_w   = '0;
      if (!SEL_ROM) begin
         sel_w = ROM_W;
      end else if (!SEL_RAM) begin
         sel_w = RAM_W;
      end else if (!SEL_IO) begin
         sel_w = IO_W;
      end else begin
         sel_hit = 1'b0;
      end
   end

   // Cycle FSM with registered strobes, wait/timeout counters and sticky flag.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= IDLE;
         wcnt      <= '0;
         tcnt      <= '0;
         DTACK     <= 1'b1;
         BERR      <= 1'b1;
         VPA       <= 1'b1;
         BERR_FLAG <= 1'b0;
      end else begin
         // A set later in this block overrides the clear on the same edge.
         if (CLR_FLAG) begin
            BERR_FLAG <= 1'b0;
         end

         case (state)
            IDLE: begin
               tcnt <= '0;
               if (!AS) begin
                  if (FC == 3'b111) begin
                     state <= VACK;
                     VPA   <= 1'b0;
                  end else if (sel_hit) begin
                     if (sel_w == 16'd0) begin
                        state <= ACK;
                        DTACK <= 1'b0;
                     end else begin
                        state <= WAIT;
                        wcnt  <= sel_w;
                     end
                  end else begin
                     state <= EXTW;
                  end
               end
            end

            // Timeout beats wait expiry so an oversized wait count still ends in BERR.
            WAIT: begin
               if (AS) begin
                  state <= IDLE;
               end else if (timeout_hit) begin
                  state     <= BERRS;
                  BERR      <= 1'b0;
                  BERR_FLAG <= 1'b1;
               end else if (wcnt == 16'd1) begin
                  state <= ACK;
                  DTACK <= 1'b0;
               end else begin
                  wcnt <= wcnt - 16'd1;
                  tcnt <= tcnt_inc[7:0];
               end
            end

            // An expansion DTACK arriving on the timeout edge still wins.
            EXTW: begin
               if (AS) begin
                  state <= IDLE;
               end else if (!EXT_DTACK) begin
                  state <= ACK;
                  DTACK <= 1'b0;
               end else if (timeout_hit) begin
                  state     <= BERRS;
                  BERR      <= 1'b0;
                  BERR_FLAG <= 1'b1;
               end else begin
                  tcnt <= tcnt_inc[7:0];
               end
            end

            ACK, VACK, BERRS: begin
               if (AS) begin
                  state <= IDLE;
                  DTACK <= 1'b1;
                  BERR  <= 1'b1;
                  VPA   <= 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               DTACK <= 1'b1;
               BERR  <= 1'b1;
               VPA   <= 1'b1;
            end
         endcase
      end
   end

endmodule
